// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer for a 1-bit ALU slice: streams operands LSB first over N
// cycles, collects the slice's sum bits and reports result, carry, ovf and zero.
module alu_bitserial_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         alu_a,
  output logic         alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  input  logic         alu_s,
  input  logic         alu_cout
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   res_sh_q, res_sh_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cy_q, cy_d;
  logic [N-1:0]   result_q, result_d;
  logic           carry_q, carry_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic [N-1:0]   assembled;

  // Value the result register holds once the current sum bit is shifted in.
  assign assembled = {alu_s, res_sh_q[N-1:1]};

  // NOTE: every variable gets its hold value first, so no path through this
  // block can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_RUN: begin
        res_sh_d = assembled;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = alu_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_DONE;
          result_d = assembled;
          carry_d  = op_q[1] & alu_cout;
          // cy_q is the carry into the MSB during this last bit.
          ovf_d    = op_q[1] & (cy_q ^ alu_cout);
          zero_d   = (assembled == '0);
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d  = S_RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op;
          cnt_d    = '0;
          cy_d     = (op == 2'b11);
          res_sh_d = '0;
        end
      end
    endcase
  end

  // NOTE: datapath registers are reset too, so alu_* and the flags are
  // defined from the moment rst asserts rather than holding stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= 2'b00;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking updates let every flop see pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign carry   = carry_q;
  assign ovf     = ovf_q;
  assign zero    = zero_q;
  assign alu_a   = a_sh_q[0];
  assign alu_b   = b_sh_q[0];
  assign alu_cin = cy_q & op_q[1];
  assign alu_op  = op_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Scoreboard bench for alu_bitserial_seq with a behavioural 1-bit slice attached.
module tb_alu_bitserial_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, carry, ovf, zero;
  logic [N-1:0] result;
  logic         alu_a, alu_b, alu_cin, alu_s, alu_cout;
  logic [1:0]   alu_op;

  typedef struct {
    logic [N-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  alu_bitserial_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf),
    .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_s(alu_s), .alu_cout(alu_cout)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice: SUB inverts b internally; the sequencer supplies cin=1 for it.
  always_comb begin
    logic bb;
    bb       = alu_b ^ (alu_op == 2'b11);
    alu_s    = 1'b0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: alu_s = ~(alu_a | alu_b);
      2'b01: alu_s = alu_a ^ alu_b;
      default: begin
        alu_s    = alu_a ^ bb ^ alu_cin;
        alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    int   sa, sb_, sr;
    sa  = $signed(x);
    sb_ = $signed(y);
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      2'b00: e.res = ~(x | y);
      2'b01: e.res = x ^ y;
      2'b10: begin
        e.res = N'(int'(x) + int'(y));
        e.c   = (int'(x) + int'(y)) >= (1 << N);
        sr    = sa + sb_;
        e.v   = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
      end
      default: begin
        e.res = N'(int'(x) - int'(y));
        e.c   = x >= y;
        sr    = sa - sb_;
        e.v   = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
      end
    endcase
    e.z   = (e.res == 0);
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT signals done.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("carry", 32'(carry), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
        check("latency", 32'(cyc - e.cyc), 32'(N));
      end
    end
  end

  // Present an op so it is accepted at the next rising edge; returns 1 ns after it.
  task automatic start_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                          input bit keep = 1'b0);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    e     = model(o, x, y);
    e.cyc = cyc;
    sb.push_back(e);
    check("busy_after_start", 32'(busy), 32'd1);
    check("alu_op_latched", 32'(alu_op), 32'(o));
    check("alu_cin_init", 32'(alu_cin), 32'(o == 2'b11));
    check("alu_a_lsb", 32'(alu_a), 32'(x[0]));
    if (!keep) start = 1'b0;
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done();
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: got no done expected done within %0d cycles", N + 4);
  endtask

  initial begin
    int t1, t2, dc;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, carry, ovf, zero}, 32'b001);
    check("rst_alu", {28'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(2'b10, 8'h7F, 8'h01); wait_done(); @(negedge clk);
    start_op(2'b11, 8'h05, 8'h05); wait_done(); @(negedge clk);
    start_op(2'b11, 8'h03, 8'h05); wait_done(); @(negedge clk);
    start_op(2'b00, 8'hF0, 8'h0F); wait_done(); @(negedge clk);
    start_op(2'b01, 8'hAA, 8'hFF); wait_done(); @(negedge clk);

    // Start pulsed mid-run with different operands must be ignored.
    dc = done_cnt;
    start_op(2'b10, 8'hFF, 8'h01);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 8'h00; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (N + 3) @(negedge clk);
    check("single_done", 32'(done_cnt - dc), 32'd1);

    // Back-to-back with start held high through DONE.
    start_op(2'b10, 8'h10, 8'h20, 1'b1);
    wait_done();
    t1 = cyc;
    start_op(2'b10, 8'h01, 8'h01, 1'b1);
    wait_done();
    t2 = cyc;
    start = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'(N + 1));
    repeat (3) @(negedge clk);

    // Reset mid-run at bit 4.
    dc = done_cnt;
    start_op(2'b10, 8'h80, 8'h80);
    repeat (4) @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    start_op(2'b10, 8'h80, 8'h80); wait_done(); @(negedge clk);

    // Randomized ops, mixing idle gaps with back-to-back issue from DONE.
    for (int i = 0; i < 40; i++) begin
      start_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (N + 3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
